// File: rtl/clk_div_bank.sv
// Multi-channel clock divider bank: CH independent divided clocks from one
// reference, each with enable, shadowed ratio/trim, tick and lock outputs.
module clk_div_chan #(
    parameter int DIV_W  = 8,
    parameter int TRIM_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [TRIM_W-1:0] trim_i,
    output logic              clk_o,
    output logic              tick_o,
    output logic              lock_o
);
    localparam int CW = DIV_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_s_q, div_s_d;
    logic [TRIM_W-1:0] trim_s_q, trim_s_d;
    logic              clk_q, clk_d;
    logic              tick_q, tick_d;
    logic              lock_q, lock_d;
    logic              cnt_zero;
    logic              same_cfg;
    logic [CW-1:0]     low_len;

    assign cnt_zero = (cnt_q == '0);
    assign same_cfg = (div_i == div_s_q) && (trim_i == trim_s_q);
    // Extended width keeps div+trim from wrapping at all-ones ratio
    assign low_len  = {1'b0, div_s_q} + CW'(trim_s_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_s_q  <= '0;
            trim_s_q <= '0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_s_q  <= div_s_d;
            trim_s_q <= trim_s_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            lock_q   <= lock_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_s_d  = div_s_q;
        trim_s_d = trim_s_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        lock_d   = lock_q;
        unique case (state_q)
            IDLE: begin
                clk_d = 1'b0;
                if (en_i) begin
                    div_s_d  = div_i;
                    trim_s_d = trim_i;
                    cnt_d    = {1'b0, div_i};
                    state_d  = HIGH;
                    clk_d    = 1'b1;
                    tick_d   = 1'b1;
                    lock_d   = 1'b0;
                end
            end
            HIGH: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = LOW;
                    clk_d   = 1'b0;
                    cnt_d   = low_len;
                end
            end
            LOW: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (en_i) begin
                    div_s_d  = div_i;
                    trim_s_d = trim_i;
                    cnt_d    = {1'b0, div_i};
                    state_d  = HIGH;
                    clk_d    = 1'b1;
                    tick_d   = 1'b1;
                    lock_d   = same_cfg;
                end else begin
                    state_d = IDLE;
                    lock_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                clk_d   = 1'b0;
                lock_d  = 1'b0;
            end
        endcase
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign lock_o = lock_q;
endmodule

module clk_div_bank #(
    parameter int CH     = 3,
    parameter int DIV_W  = 8,
    parameter int TRIM_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH-1:0]        en,
    input  logic [CH*DIV_W-1:0]  div,
    input  logic [CH*TRIM_W-1:0] trim,
    output logic [CH-1:0]        clk_out,
    output logic [CH-1:0]        tick,
    output logic [CH-1:0]        lock
);
    for (genvar i = 0; i < CH; i++) begin : g_ch
        clk_div_chan #(
            .DIV_W  (DIV_W),
            .TRIM_W (TRIM_W)
        ) u_chan (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .en_i   (en[i]),
            .div_i  (div[i*DIV_W +: DIV_W]),
            .trim_i (trim[i*TRIM_W +: TRIM_W]),
            .clk_o  (clk_out[i]),
            .tick_o (tick[i]),
            .lock_o (lock[i])
        );
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: period-position reference model compared every
// cycle, plus directed phase-length and lock measurements.
module tb_clk_div_bank;
    localparam int CH     = 3;
    localparam int DIV_W  = 8;
    localparam int TRIM_W = 2;

    logic                 clk;
    logic                 rst_n;
    logic [CH-1:0]        en;
    logic [CH*DIV_W-1:0]  div;
    logic [CH*TRIM_W-1:0] trim;
    logic [CH-1:0]        clk_out;
    logic [CH-1:0]        tick;
    logic [CH-1:0]        lock;

    int checks   = 0;
    int failures = 0;

    clk_div_bank #(
        .CH     (CH),
        .DIV_W  (DIV_W),
        .TRIM_W (TRIM_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div     (div),
        .trim    (trim),
        .clk_out (clk_out),
        .tick    (tick),
        .lock    (lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within the current period, config latched at
    // each period start.
    bit m_run[CH];
    int m_pos[CH];
    int m_div[CH];
    int m_trim[CH];
    bit m_lock[CH];

    initial begin
        for (int i = 0; i < CH; i++) begin
            m_run[i] = 0; m_pos[i] = 0; m_div[i] = 0;
            m_trim[i] = 0; m_lock[i] = 0;
        end
    end

    always begin
        logic [CH-1:0] e_clk, e_tick, e_lock;
        int nd, nt;
        @(posedge clk);
        for (int i = 0; i < CH; i++) begin
            nd = int'(div[i*DIV_W +: DIV_W]);
            nt = int'(trim[i*TRIM_W +: TRIM_W]);
            if (!rst_n) begin
                m_run[i] = 0; m_pos[i] = 0; m_lock[i] = 0;
            end else if (!m_run[i]) begin
                if (en[i]) begin
                    m_run[i] = 1; m_pos[i] = 0; m_lock[i] = 0;
                    m_div[i] = nd; m_trim[i] = nt;
                end
            end else begin
                m_pos[i]++;
                if (m_pos[i] == 2 * (m_div[i] + 1) + m_trim[i]) begin
                    if (en[i]) begin
                        m_lock[i] = (nd == m_div[i]) && (nt == m_trim[i]);
                        m_div[i]  = nd;
                        m_trim[i] = nt;
                        m_pos[i]  = 0;
                    end else begin
                        m_run[i]  = 0;
                        m_lock[i] = 0;
                    end
                end
            end
        end
        #1;
        for (int i = 0; i < CH; i++) begin
            e_clk[i]  = m_run[i] && (m_pos[i] <= m_div[i]);
            e_tick[i] = m_run[i] && (m_pos[i] == 0);
            e_lock[i] = m_lock[i];
        end
        checks++;
        if (clk_out !== e_clk || tick !== e_tick || lock !== e_lock) begin
            failures++;
            $display("FAIL model t=%0t clk_out=%b/%b tick=%b/%b lock=%b/%b (got/exp)",
                     $time, clk_out, e_clk, tick, e_tick, lock, e_lock);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic set_cfg(input int ch, input int d, input int t);
        div[ch*DIV_W +: DIV_W]    = DIV_W'(d);
        trim[ch*TRIM_W +: TRIM_W] = TRIM_W'(t);
    endtask

    task automatic wait_tick(input int ch);
        bit seen = 0;
        for (int n = 0; n < 1200 && !seen; n++) begin
            @(negedge clk);
            if (tick[ch]) seen = 1;
        end
        chk("wait_tick_timeout", int'(seen), 1);
    endtask

    // Starts at a tick cycle; ends at the next rising edge of clk_out
    task automatic measure(input int ch, output int hi, output int lo);
        int n = 0;
        hi = 0; lo = 0;
        while (clk_out[ch] && n < 1200) begin
            hi++; n++; @(negedge clk);
        end
        while (!clk_out[ch] && n < 1200) begin
            lo++; n++; @(negedge clk);
        end
    endtask

    initial begin
        int hi, lo, nt;
        rst_n = 1'b0;
        en    = '0;
        div   = '0;
        trim  = '0;
        #12;
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_lock", int'(lock), 0);

        @(negedge clk);
        rst_n = 1'b1;
        set_cfg(0, 3, 0);
        set_cfg(1, 3, 2);
        set_cfg(2, 3, 0);
        @(negedge clk);
        en[0] = 1'b1;
        @(negedge clk);
        chk("en_latency_clk", int'(clk_out[0]), 1);
        chk("en_latency_tick", int'(tick[0]), 1);
        chk("first_tick_lock", int'(lock[0]), 0);
        measure(0, hi, lo);
        chk("ch0_hi", hi, 4);
        chk("ch0_lo", lo, 4);
        chk("ch0_lock_2nd", int'(lock[0]), 1);

        en[1] = 1'b1;
        wait_tick(1);
        measure(1, hi, lo);
        chk("ch1_hi", hi, 4);
        chk("ch1_lo", lo, 6);
        set_cfg(1, 0, 0);
        measure(1, hi, lo);
        chk("ch1_hold_hi", hi, 4);
        chk("ch1_hold_lo", lo, 6);
        chk("ch1_lock_drop", int'(lock[1]), 0);
        measure(1, hi, lo);
        chk("ch1_div0_hi", hi, 1);
        chk("ch1_div0_lo", lo, 1);

        wait_tick(0);
        set_cfg(0, 1, 0);
        measure(0, hi, lo);
        chk("ch0_cur_hi", hi, 4);
        chk("ch0_cur_lo", lo, 4);
        chk("ch0_lock_drop", int'(lock[0]), 0);
        measure(0, hi, lo);
        chk("ch0_new_hi", hi, 2);
        chk("ch0_new_lo", lo, 2);
        chk("ch0_lock_back", int'(lock[0]), 1);

        en[2] = 1'b1;
        wait_tick(2);
        @(negedge clk);
        en[2] = 1'b0;
        hi = 1;
        for (int n = 0; n < 20 && clk_out[2]; n++) begin
            hi++; @(negedge clk);
        end
        chk("ch2_drop_hi", hi, 4);
        nt = 0;
        for (int n = 0; n < 30; n++) begin
            if (tick[2] || clk_out[2]) nt++;
            @(negedge clk);
        end
        chk("ch2_no_tick", nt, 0);
        chk("ch2_lock_off", int'(lock[2]), 0);

        set_cfg(2, 0, 1);
        en[2] = 1'b1;
        set_cfg(1, 255, 3);
        wait_tick(1);
        measure(1, hi, lo);
        chk("ch1_max_hi", hi, 256);
        chk("ch1_max_lo", lo, 259);

        for (int n = 0; n < 20 && clk_out[0]; n++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_clk", int'(clk_out), 0);
        chk("async_rst_tick", int'(tick), 0);
        chk("async_rst_lock", int'(lock), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_clk", int'(clk_out), 7);
        chk("restart_tick", int'(tick), 7);

        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
